// File: rtl/hx8352_bus_writer_pkg.sv
// Shared definitions for the HX8352 parallel-bus writer: RS polarity, pin levels, FSM states.
// The main FSM imports the same RS convention so command/data encoding cannot drift.
package hx8352_bus_writer_pkg;

    localparam int unsigned DB_W = 16;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;
    localparam logic HIGH     = 1'b1;
    localparam logic LOW      = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWrLow,
        StWrHigh
    } bw_state_e;

endpackage

// File: rtl/hx8352_bus_writer_if.sv
// Request/response and LCD pin bundle between the requester (master) and the bus writer (slave).
interface hx8352_bus_writer_if;
    import hx8352_bus_writer_pkg::*;

    logic            bus_step;
    logic            command_or_data;
    logic [DB_W-1:0] data_to_write;
    logic            bus_done;
    logic            busy;
    logic            overflow;
    logic            lcd_rs;
    logic            lcd_wr;
    logic            lcd_rd;
    logic [DB_W-1:0] lcd_db;

    modport master (
        output bus_step, command_or_data, data_to_write,
        input  bus_done, busy, overflow, lcd_rs, lcd_wr, lcd_rd, lcd_db
    );

    modport slave (
        input  bus_step, command_or_data, data_to_write,
        output bus_done, busy, overflow, lcd_rs, lcd_wr, lcd_rd, lcd_db
    );

endinterface

// File: rtl/hx8352_bus_writer.sv
// Turns one bus_step request into one 8080-style write cycle (setup, WR low, WR high) on the
// HX8352 parallel bus, with a one-deep pending slot for a request arriving mid-cycle.
module hx8352_bus_writer
    import hx8352_bus_writer_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2,
    parameter int unsigned CNT_W          = 4
) (
    input logic                clk,
    input logic                rst,
    hx8352_bus_writer_if.slave bus
);

    localparam logic [CNT_W-1:0] SetupLoad  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WrLowLoad  = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WrHighLoad = CNT_W'(WR_HIGH_CYCLES - 1);

    bw_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            pend_full_q, pend_full_d;
    logic            pend_rs_q, pend_rs_d;
    logic [DB_W-1:0] pend_db_q, pend_db_d;
    logic            rs_q, rs_d;
    logic [DB_W-1:0] db_q, db_d;
    logic            wr_q, wr_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic            rd_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_rs_d   = pend_rs_q;
        pend_db_d   = pend_db_q;
        rs_d        = rs_q;
        db_d        = db_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;

        case (state_q)
            StIdle: begin
                if (pend_full_q) begin
                    // Launch the queued entry; a coinciding request refills the freed slot.
                    state_d     = StSetup;
                    cnt_d       = SetupLoad;
                    rs_d        = pend_rs_q;
                    db_d        = pend_db_q;
                    pend_full_d = bus.bus_step;
                    if (bus.bus_step) begin
                        pend_rs_d = bus.command_or_data;
                        pend_db_d = bus.data_to_write;
                    end
                end else if (bus.bus_step) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                    rs_d    = bus.command_or_data;
                    db_d    = bus.data_to_write;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StWrLow;
                    cnt_d   = WrLowLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrLow: begin
                if (cnt_q == '0) begin
                    state_d = StWrHigh;
                    cnt_d   = WrHighLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHigh: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (state_q != StIdle && bus.bus_step) begin
            if (!pend_full_q) begin
                pend_full_d = 1'b1;
                pend_rs_d   = bus.command_or_data;
                pend_db_d   = bus.data_to_write;
            end else begin
                ovf_d = 1'b1;
            end
        end

        wr_d   = (state_d == StWrLow) ? LOW : HIGH;
        // Busy also covers the bus_done cycle so it drops only after the last completion.
        busy_d = (state_d != StIdle) | pend_full_d | done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_rs_q   <= LCD_CMD;
            pend_db_q   <= '0;
            rs_q        <= LCD_CMD;
            db_q        <= '0;
            wr_q        <= HIGH;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rd_q        <= HIGH;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_rs_q   <= pend_rs_d;
            pend_db_q   <= pend_db_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            wr_q        <= wr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            rd_q        <= HIGH;
        end
    end

    assign bus.bus_done = done_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_wr   = wr_q;
    assign bus.lcd_rd   = rd_q;
    assign bus.lcd_db   = db_q;

endmodule

// File: tb/tb_hx8352_bus_writer.sv
// Directed bench for hx8352_bus_writer: inputs are driven and outputs sampled on the falling edge,
// so the sample at falling edge i reflects cycle k+i after a request driven in cycle k.
module tb_hx8352_bus_writer;
    import hx8352_bus_writer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hx8352_bus_writer_if bus0 ();
    hx8352_bus_writer_if bus1 ();

    hx8352_bus_writer u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    hx8352_bus_writer #(
        .SETUP_CYCLES   (3),
        .WR_LOW_CYCLES  (4),
        .WR_HIGH_CYCLES (1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step0(input logic cod, input logic [15:0] d);
        bus0.bus_step        = 1'b1;
        bus0.command_or_data = cod;
        bus0.data_to_write   = d;
    endtask

    // Junk on the data inputs must be ignored while bus_step is low.
    task automatic idle0();
        bus0.bus_step        = 1'b0;
        bus0.command_or_data = 1'b1;
        bus0.data_to_write   = 16'hDEAD;
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_done"}, bus0.bus_done, 0);
        check({tag, "_busy"}, bus0.busy, 0);
        check({tag, "_ovf"}, bus0.overflow, 0);
        check({tag, "_rs"}, bus0.lcd_rs, 0);
        check({tag, "_wr"}, bus0.lcd_wr, 1);
        check({tag, "_rd"}, bus0.lcd_rd, 1);
        check({tag, "_db"}, bus0.lcd_db, 16'h0000);
    endtask

    initial begin
        int          dones;
        logic        found;
        logic [15:0] data;

        rst = 1'b1;
        idle0();
        bus1.bus_step        = 1'b0;
        bus1.command_or_data = 1'b0;
        bus1.data_to_write   = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset0("rst");
        check("rst_dut1_wr", bus1.lcd_wr, 1);
        rst = 1'b0;

        // 1: command write 0x0022
        @(negedge clk);
        step0(LCD_CMD, 16'h0022);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            idle0();
            check("t1_wr", bus0.lcd_wr, (i == 2 || i == 3) ? 1'b0 : 1'b1);
            check("t1_done", bus0.bus_done, (i == 6) ? 1'b1 : 1'b0);
            check("t1_db", bus0.lcd_db, 16'h0022);
            check("t1_rs", bus0.lcd_rs, 0);
            check("t1_busy", bus0.busy, (i <= 6) ? 1'b1 : 1'b0);
        end

        // 2: data write 0xF800 with SETUP=3, WR_LOW=4, WR_HIGH=1
        @(negedge clk);
        bus1.bus_step        = 1'b1;
        bus1.command_or_data = LCD_DATA;
        bus1.data_to_write   = 16'hF800;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            bus1.bus_step      = 1'b0;
            bus1.data_to_write = 16'h0BAD;
            check("t2_wr", bus1.lcd_wr, (i >= 4 && i <= 7) ? 1'b0 : 1'b1);
            check("t2_done", bus1.bus_done, (i == 9) ? 1'b1 : 1'b0);
            check("t2_db", bus1.lcd_db, 16'hF800);
            check("t2_rs", bus1.lcd_rs, 1);
        end

        // 3: back-to-back, second request at k+2 goes through the pending slot
        @(negedge clk);
        step0(LCD_DATA, 16'hAAAA);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 2) step0(LCD_CMD, 16'h1234);
            else idle0();
            check("t3_busy", bus0.busy, (i <= 12) ? 1'b1 : 1'b0);
            check("t3_done", bus0.bus_done, (i == 6 || i == 12) ? 1'b1 : 1'b0);
            check("t3_wr", bus0.lcd_wr,
                  (i == 2 || i == 3 || i == 8 || i == 9) ? 1'b0 : 1'b1);
            check("t3_db", bus0.lcd_db, (i <= 6) ? 16'hAAAA : 16'h1234);
            check("t3_rs", bus0.lcd_rs, (i <= 6) ? 1'b1 : 1'b0);
        end

        // 4: three requests in a row, the third overflows
        @(negedge clk);
        step0(LCD_DATA, 16'h0001);
        dones = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) step0(LCD_DATA, 16'h0002);
            else if (i == 2) step0(LCD_DATA, 16'h0003);
            else idle0();
            if (bus0.bus_done) dones++;
            if (i == 7) check("t4_db2", bus0.lcd_db, 16'h0002);
            if (i >= 2) check("t4_ovf", bus0.overflow, (i >= 3) ? 1'b1 : 1'b0);
        end
        check("t4_dones", dones, 2);
        check("t4_db_final", bus0.lcd_db, 16'h0002);

        // 5: reset while WR is low
        @(negedge clk);
        step0(LCD_DATA, 16'h7777);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            idle0();
            if (i == 2) begin
                check("t5_wr_low", bus0.lcd_wr, 0);
                rst = 1'b1;
            end
        end
        check_reset0("t5");
        rst   = 1'b0;
        dones = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus0.bus_done) dones++;
        end
        check("t5_no_done", dones, 0);
        step0(LCD_DATA, 16'h5A5A);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            idle0();
            check("t5_done", bus0.bus_done, (i == 6) ? 1'b1 : 1'b0);
            check("t5_db", bus0.lcd_db, 16'h5A5A);
        end

        // 6: main-FSM style, 64 writes each one cycle after the previous bus_done
        dones = 0;
        for (int n = 0; n < 64; n++) begin
            data = 16'(n * 16'h0405 + 16'h1100);
            @(negedge clk);
            check("t6_idle_busy", bus0.busy, 0);
            step0(LCD_DATA, data);
            found = 1'b0;
            for (int c = 1; c <= 20 && !found; c++) begin
                @(negedge clk);
                idle0();
                if (bus0.bus_done) begin
                    found = 1'b1;
                    dones++;
                    check("t6_db", bus0.lcd_db, data);
                    check("t6_lat", c, 6);
                end
            end
            check("t6_done_seen", found, 1);
        end
        check("t6_dones", dones, 64);
        check("t6_ovf", bus0.overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
